// File: rtl/qpsk_iq_demod.sv
// QPSK I/Q integrate-and-dump demodulator: mixes samples with the NCO, integrates SPS products
// per symbol and slices the dumped integrals. Optional symbol re-alignment under QPSK_DEMOD_SYNC_EN.
module qpsk_iq_demod #(
  parameter int MPR = 12,
  parameter int DW  = 12,
  parameter int SPS = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clken,
  input  logic [DW-1:0]                          din,
  input  logic                                   din_valid,
  input  logic [MPR-1:0]                         fcos_i,
  input  logic [MPR-1:0]                         fsin_i,
  input  logic                                   nco_valid,
`ifdef QPSK_DEMOD_SYNC_EN
  input  logic                                   sym_sync,
`endif
  output logic [DW+MPR+$clog2(SPS+1)-1:0]        i_acc_o,
  output logic [DW+MPR+$clog2(SPS+1)-1:0]        q_acc_o,
  output logic [1:0]                             sym_o,
  output logic                                   sym_valid
);

  localparam int CW = $clog2(SPS+1);
  localparam int AW = DW + MPR + CW;
  localparam int PW = DW + MPR;
  localparam logic [CW-1:0] LAST = CW'(SPS-1);

  logic                 w_accept;
  logic                 w_sync;
  logic signed [PW-1:0] w_din_x, w_cos_x, w_sin_x;
  logic signed [PW-1:0] w_pi, w_pq;
  logic signed [AW-1:0] w_pi_x, w_pq_x, w_sum_i, w_sum_q;

  logic [CW-1:0]        r_cnt;
  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic signed [PW-1:0] r_pi, r_pq;
  logic signed [AW-1:0] r_acc_i, r_acc_q;
  logic [AW-1:0]        r_i_out, r_q_out;
  logic [1:0]           r_sym;
  logic                 r_sym_valid;

  assign w_accept = clken & din_valid & nco_valid;

`ifdef QPSK_DEMOD_SYNC_EN
  assign w_sync = clken & sym_sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_din_x = PW'($signed(din));
  assign w_cos_x = PW'($signed(fcos_i));
  assign w_sin_x = PW'($signed(fsin_i));
  assign w_pi    = w_din_x * w_cos_x;
  assign w_pq    = w_din_x * w_sin_x;

  assign w_pi_x  = {{CW{r_pi[PW-1]}}, r_pi};
  assign w_pq_x  = {{CW{r_pq[PW-1]}}, r_pq};
  assign w_sum_i = r_acc_i + w_pi_x;
  assign w_sum_q = r_acc_q + w_pq_x;

  // Stage 1: products plus a tag marking the final sample of the symbol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_pi       <= '0;
      r_pq       <= '0;
    end else if (clken) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_pi <= w_pi;
        r_pq <= w_pq;
      end
      if (w_sync) begin
        // a sample arriving with the strobe becomes sample 0 of the new symbol
        r_cnt     <= w_accept ? CW'(1) : '0;
        r_s1_last <= 1'b0;
      end else if (w_accept) begin
        r_s1_last <= (r_cnt == LAST);
        r_cnt     <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
    end
  end

  // Stage 2: integrate, or dump the final sum and restart from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_sym       <= 2'b00;
      r_sym_valid <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      if (clken) begin
        if (w_sync) begin
          r_acc_i <= '0;
          r_acc_q <= '0;
        end else if (r_s1_valid) begin
          if (r_s1_last) begin
            r_i_out     <= w_sum_i;
            r_q_out     <= w_sum_q;
            r_sym       <= {w_sum_i[AW-1], w_sum_q[AW-1]};
            r_sym_valid <= 1'b1;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
          end else begin
            r_acc_i <= w_sum_i;
            r_acc_q <= w_sum_q;
          end
        end
      end
    end
  end

  assign i_acc_o   = r_i_out;
  assign q_acc_o   = r_q_out;
  assign sym_o     = r_sym;
  assign sym_valid = r_sym_valid;

endmodule

// File: doc/qpsk_iq_demod.md
QPSK_IQ_DEMOD -- requirements
Module: qpsk_iq_demod

Interface
REQ-001 SHALL have parameter MPR, default 12: NCO sine/cosine word width (two's complement).
REQ-002 SHALL have parameter DW, default 12: received sample width (two's complement).
REQ-003 SHALL have parameter SPS, default 32, legal range 2..1024: samples per QPSK symbol.
REQ-004 SHALL derive localparam CW = clog2(SPS+1) and localparam AW = DW+MPR+CW.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port clken, input, 1 bit: global clock enable.
REQ-008 SHALL have port din, input, DW bits: received passband sample.
REQ-009 SHALL have port din_valid, input, 1 bit: din qualifier.
REQ-010 SHALL have port fcos_i, input, MPR bits: NCO cosine word.
REQ-011 SHALL have port fsin_i, input, MPR bits: NCO sine word.
REQ-012 SHALL have port nco_valid, input, 1 bit: NCO output-valid flag.
REQ-013 SHALL have port sym_sync, input, 1 bit: symbol-alignment strobe; present only under QPSK_DEMOD_SYNC_EN.
REQ-014 SHALL have port i_acc_o, output, AW bits: dumped in-phase integral (signed).
REQ-015 SHALL have port q_acc_o, output, AW bits: dumped quadrature integral (signed).
REQ-016 SHALL have port sym_o, output, 2 bits: decided dibit.
REQ-017 SHALL have port sym_valid, output, 1 bit: one-cycle pulse marking new i_acc_o, q_acc_o and sym_o.

Function
REQ-018 SHALL accept a sample on a clk edge only when clken, din_valid and nco_valid are all 1.
REQ-019 SHALL register the products at stage 1: pi = din*fcos_i and pq = din*fsin_i, each a signed full-precision DW+MPR-bit result.
REQ-020 SHALL sign-extend pi and pq to AW bits at stage 2 and add them into accumulators acc_i and acc_q; AW is sized so that SPS products never overflow.
REQ-021 SHALL run a sample counter from 0 to SPS-1 that advances once per accepted sample.
REQ-022 SHALL, when the sample with count SPS-1 reaches stage 2, latch acc_i+pi into i_acc_o and acc_q+pq into q_acc_o, load acc_i and acc_q with 0, and return the counter to 0.
REQ-023 SHALL keep a sample accepted in the cycle immediately after a dump out of the dumped symbol; no sample is lost or counted twice.
REQ-024 SHALL drive sym_o[1] = sign bit of the dumped I value and sym_o[0] = sign bit of the dumped Q value; a value of exactly 0 decides as bit 0.
REQ-025 SHALL assert sym_valid for exactly one clk cycle, 2 clken-qualified cycles after the final sample of a symbol is accepted.
REQ-026 SHALL clear sym_valid on the next clk edge regardless of clken.
REQ-027 SHALL hold all pipeline, accumulator and counter state while clken = 0.
REQ-028 SHALL, for a stage-1 product whose sample was accepted while clken was high, add that product at the next clken-high edge.
REQ-029 SHALL hold i_acc_o, q_acc_o and sym_o stable between dumps.
REQ-030 SHALL add nothing to acc_i or acc_q in a cycle where din_valid or nco_valid is 0, and the counter SHALL not advance.

Reset
REQ-031 SHALL, on reset assertion at any time including mid-symbol, clear to 0 the counter, acc_i, acc_q, stage-1 registers, i_acc_o, q_acc_o, sym_o and sym_valid.
REQ-032 SHALL start the first symbol after reset deassertion at the first accepted sample.

Configuration
REQ-033 SHALL, with QPSK_DEMOD_SYNC_EN defined, provide port sym_sync. When sym_sync = 1 and clken = 1, the block SHALL zero the counter, acc_i, acc_q and the stage-1 valid, and SHALL produce no dump.
REQ-034 SHALL, when sym_sync coincides with an accepted sample, count that sample as sample 0 of the new symbol.
REQ-035 SHALL, with QPSK_DEMOD_SYNC_EN undefined, omit sym_sync, and the counter SHALL free-run from reset only.

Verification
REQ-036 SHALL cover: SPS=4, din=+100, fcos_i=+1000, fsin_i=-1000 for 4 samples -> i_acc_o=400000, q_acc_o=-400000, sym_o=2'b01, sym_valid pulses once.
REQ-037 SHALL cover: din=-100, fcos_i=+1000, fsin_i=+1000 for 4 samples -> i_acc_o=-400000, q_acc_o=-400000, sym_o=2'b11.
REQ-038 SHALL cover: samples alternating +100/-100 with fcos_i=+1000 -> i_acc_o=0 and sym_o[1]=0.
REQ-039 SHALL cover: din_valid low on 3 cycles inside a symbol -> dump only after 4 accepted samples, same values as REQ-036.
REQ-040 SHALL cover: reset pulsed after 2 samples -> all outputs 0 and the next symbol needs 4 fresh samples.
REQ-041 SHALL cover, with QPSK_DEMOD_SYNC_EN: sym_sync after 2 samples -> no sym_valid, and the symbol restarts with that sample as sample 0.
